// File: rtl/spi_config_pkg.sv
// rtl/spi_config_pkg.sv - shared types and helpers for the SPI configuration register
package spi_config_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic {IDLE, SHIFTING} spi_cfg_state_t;

  function automatic logic [BYTE_WIDTH-1:0] xor_byte(
    input logic [BYTE_WIDTH-1:0] acc,
    input logic [BYTE_WIDTH-1:0] dataByte
  );
    return acc ^ dataByte;
  endfunction

endpackage

// File: rtl/spi_config_register.sv
// rtl/spi_config_register.sv - assembles SPI bits into frames and commits them to a config word (option: SPI_CONFIG_CHECKSUM_EN)
module spi_config_register
  import spi_config_pkg::*;
#(
  parameter int                      NUM_BYTES   = 2,
  parameter logic [NUM_BYTES*8-1:0]  RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    serialIn,
  input  logic                    serialEn,
  input  logic                    frameAbort,
  output logic [NUM_BYTES*8-1:0]  configOut,
  output logic                    configValid,
  output logic                    frameDone,
  output logic                    checksumError
);

  localparam int W = NUM_BYTES * BYTE_WIDTH;
`ifdef SPI_CONFIG_CHECKSUM_EN
  localparam int FW = W + BYTE_WIDTH;
`else
  localparam int FW = W;
`endif
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

  spi_cfg_state_t state;
  // Only FW-1 bits are stored: the newest bit arrives on serialIn and the
  // full FW-bit frame exists only combinationally on the committing strobe.
  logic [FW-2:0]  shiftReg;
  logic [CW-1:0]  bitCount;
  logic [FW-1:0]  nextShift;
  logic [CW-1:0]  curCount;

  assign nextShift = {shiftReg, serialIn};
  // A frame always starts counting from zero when leaving IDLE.
  assign curCount  = (state == IDLE) ? '0 : bitCount;

`ifdef SPI_CONFIG_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] checksumAcc;
  logic                  byteLands;

  // A data byte is complete when its 8th bit shifts in; the checksum byte is excluded.
  assign byteLands = (curCount[2:0] == 3'b111) && (curCount < CW'(W));
`else
  assign checksumError = 1'b0;
`endif

  // Frame FSM: shifting, counting, checksum accumulation and atomic commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      configOut     <= RESET_VALUE;
      configValid   <= 1'b0;
      frameDone     <= 1'b0;
      shiftReg      <= '0;
      bitCount      <= '0;
      state         <= IDLE;
`ifdef SPI_CONFIG_CHECKSUM_EN
      checksumError <= 1'b0;
      checksumAcc   <= '0;
`endif
    end else begin
      frameDone     <= 1'b0;
`ifdef SPI_CONFIG_CHECKSUM_EN
      checksumError <= 1'b0;
`endif
      if (frameAbort) begin
        // Abort wins over a simultaneous strobe; configOut is left untouched.
        shiftReg    <= '0;
        bitCount    <= '0;
        state       <= IDLE;
`ifdef SPI_CONFIG_CHECKSUM_EN
        checksumAcc <= '0;
`endif
      end else if (serialEn) begin
        shiftReg <= nextShift[FW-2:0];
        if (curCount == LAST_BIT) begin
          bitCount <= '0;
          state    <= IDLE;
`ifdef SPI_CONFIG_CHECKSUM_EN
          checksumAcc <= '0;
          if (nextShift[BYTE_WIDTH-1:0] == checksumAcc) begin
            configOut   <= nextShift[FW-1:BYTE_WIDTH];
            configValid <= 1'b1;
            frameDone   <= 1'b1;
          end else begin
            checksumError <= 1'b1;
          end
`else
          configOut   <= nextShift;
          configValid <= 1'b1;
          frameDone   <= 1'b1;
`endif
        end else begin
          bitCount <= curCount + 1'b1;
          state    <= SHIFTING;
`ifdef SPI_CONFIG_CHECKSUM_EN
          if (byteLands) begin
            checksumAcc <= xor_byte(checksumAcc, nextShift[BYTE_WIDTH-1:0]);
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_config_register.sv
// tb/tb_spi_config_register.sv - self-checking bench for spi_config_register
module tb_spi_config_register;

  localparam int W = 16;
`ifdef SPI_CONFIG_CHECKSUM_EN
  localparam int FW = 24;
`else
  localparam int FW = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        serialIn;
  logic        serialEn;
  logic        frameAbort;
  logic [15:0] configOut;
  logic        configValid;
  logic        frameDone;
  logic        checksumError;

  spi_config_register #(
    .NUM_BYTES   (2),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serialIn      (serialIn),
    .serialEn      (serialEn),
    .frameAbort    (frameAbort),
    .configOut     (configOut),
    .configValid   (configValid),
    .frameDone     (frameDone),
    .checksumError (checksumError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int doneCount = 0;
  int errCount = 0;
  int doneCycles[$];

  // Reference model: a list of received bits, turned into a word when full.
  bit          mBits[$];
  logic [31:0] mWord;
  logic [15:0] expCfg;
  logic        expValid;
  logic        expDone;
  logic        expErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  // Model update on every clock edge, or immediately on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mBits.delete();
      expCfg   = 16'h0000;
      expValid = 1'b0;
      expDone  = 1'b0;
      expErr   = 1'b0;
    end else begin
      expDone = 1'b0;
      expErr  = 1'b0;
      if (frameAbort) begin
        mBits.delete();
      end else if (serialEn) begin
        mBits.push_back(serialIn);
        if (mBits.size() == FW) begin
          mWord = 32'h0;
          foreach (mBits[i]) mWord = {mWord[30:0], mBits[i]};
`ifdef SPI_CONFIG_CHECKSUM_EN
          if (mWord[7:0] == (mWord[23:16] ^ mWord[15:8])) begin
            expCfg   = mWord[23:8];
            expValid = 1'b1;
            expDone  = 1'b1;
          end else begin
            expErr = 1'b1;
          end
`else
          expCfg   = mWord[15:0];
          expValid = 1'b1;
          expDone  = 1'b1;
`endif
          mBits.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("configOut", configOut, expCfg);
      check("configValid", configValid, expValid);
      check("frameDone", frameDone, expDone);
      check("checksumError", checksumError, expErr);
      if (frameDone === 1'b1) begin
        doneCount++;
        doneCycles.push_back(cycle);
      end
      if (checksumError === 1'b1) errCount++;
    end
  end

  // Called at a negedge; returns at a negedge after the strobe plus gap cycles.
  task automatic sendBit(input logic b, input int gap);
    serialIn = b;
    serialEn = 1'b1;
    @(negedge clk);
    serialEn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) sendBit(v[i], gap);
  endtask

  task automatic sendFrame(input logic [15:0] v, input int gap);
    sendByte(v[15:8], gap);
    sendByte(v[7:0], gap);
`ifdef SPI_CONFIG_CHECKSUM_EN
    sendByte(v[15:8] ^ v[7:0], gap);
`endif
  endtask

  int base;
  int baseErr;

  initial begin
    reset      = 1'b1;
    serialIn   = 1'b0;
    serialEn   = 1'b0;
    frameAbort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_configOut", configOut, 32'h0);
    check("rst_configValid", configValid, 32'h0);
    check("rst_frameDone", frameDone, 32'h0);
    check("rst_checksumError", checksumError, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic frame with gaps
    sendFrame(16'hA53C, 3);
    check("t1_configOut", configOut, 32'hA53C);
    check("t1_configValid", configValid, 32'h1);
    check("t1_doneCount", doneCount, 32'd1);

    // 2: partial frame aborted, then a full frame
    base = doneCount;
    sendBit(1'b1, 1); sendBit(1'b0, 1); sendBit(1'b1, 1); sendBit(1'b1, 1); sendBit(1'b0, 1);
    frameAbort = 1'b1;
    repeat (2) @(negedge clk);
    frameAbort = 1'b0;
    check("t2_no_done_on_abort", doneCount, base);
    check("t2_cfg_kept", configOut, 32'hA53C);
    sendFrame(16'h1234, 1);
    repeat (2) @(negedge clk);
    check("t2_configOut", configOut, 32'h1234);
    check("t2_doneCount", doneCount, base + 1);

    // 3: abort coincident with a strobe mid-frame
    for (int i = 0; i < 7; i++) sendBit(1'b1, 0);
    serialIn   = 1'b1;
    serialEn   = 1'b1;
    frameAbort = 1'b1;
    @(negedge clk);
    serialEn   = 1'b0;
    frameAbort = 1'b0;
    @(negedge clk);
    check("t3_cfg_kept", configOut, 32'h1234);
    sendFrame(16'hC3A1, 1);
    repeat (2) @(negedge clk);
    check("t3_realigned", configOut, 32'hC3A1);

    // 4: two frames on consecutive strobes
    base = doneCount;
    doneCycles.delete();
    sendFrame(16'hBEEF, 0);
    sendFrame(16'h0001, 0);
    repeat (3) @(negedge clk);
    check("t4_doneCount", doneCount, base + 2);
    if (doneCycles.size() >= 2) check("t4_spacing", doneCycles[1] - doneCycles[0], FW);
    check("t4_configOut", configOut, 32'h0001);

    // 5: asynchronous reset between edges
    for (int i = 0; i < 9; i++) sendBit(i[0], 1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_cfg", configOut, 32'h0);
    check("t5_async_valid", configValid, 32'h0);
    check("t5_async_done", frameDone, 32'h0);
    check("t5_async_err", checksumError, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sendFrame(16'h5A0F, 1);
    repeat (2) @(negedge clk);
    check("t5_configOut", configOut, 32'h5A0F);
    check("t5_configValid", configValid, 32'h1);

`ifdef SPI_CONFIG_CHECKSUM_EN
    // 6: checksum match then mismatch
    sendByte(8'hA5, 1); sendByte(8'h3C, 1); sendByte(8'h99, 1);
    repeat (2) @(negedge clk);
    check("t6_match_cfg", configOut, 32'hA53C);
    base    = doneCount;
    baseErr = errCount;
    sendByte(8'h11, 1); sendByte(8'h22, 1); sendByte(8'h00, 1);
    repeat (2) @(negedge clk);
    check("t6_mismatch_cfg", configOut, 32'hA53C);
    check("t6_err_pulse", errCount, baseErr + 1);
    check("t6_no_done", doneCount, base);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
